spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_pkg.sv | 36 +++
 rtl/spi_clk_gen.sv | 49 ++++
 rtl/spi_master.sv | 154 +++++++++++++++
 tb/tb_spi_master.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM encoding, message-length codes,
// default timing constants and the transfer-length helper.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    SCK_HI = 3'd2,
    SCK_LO = 3'd3,
    HOLD   = 3'd4,
    GAP    = 3'd5
  } spi_state_t;

  localparam logic [3:0] NO_BY      = 4'd0;
  localparam logic [3:0] ONE_BY     = 4'd1;
  localparam logic [3:0] STD_TWO_BY = 4'd2;
  localparam logic [3:0] THREE_BY   = 4'd3;
  localparam logic [3:0] SIX_BY     = 4'd6;
  localparam logic [3:0] LONG       = 4'd7;

  localparam logic [3:0] MAX_BYTES  = 4'd8;

  localparam int DEF_CLK_DIV_HALF = 8;
  localparam int DEF_CS_SETUP     = 8;
  localparam int DEF_CS_HOLD      = 8;
  localparam int DEF_CS_GAP       = 8;

  // Zero or anything above eight bytes means a full 64-bit transfer.
  function automatic logic [6:0] calc_nbits(input logic [3:0] byte_count);
    logic [3:0] len;
    len = byte_count;
    if (byte_count == NO_BY || byte_count > MAX_BYTES) len = MAX_BYTES;
    return {len, 3'b000};
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Phase timer for the SPI master: one down-counter reloaded on every state
// change, producing end-of-phase and SCK rise/fall strobes.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV_HALF = DEF_CLK_DIV_HALF,
  parameter int CS_SETUP     = DEF_CS_SETUP,
  parameter int CS_HOLD      = DEF_CS_HOLD,
  parameter int CS_GAP       = DEF_CS_GAP
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic [2:0] state,
  input  logic [2:0] next_state,
  output logic       phase_done,
  output logic       sck_rise,
  output logic       sck_fall
);

  logic [7:0] cnt;
  logic [7:0] load_val;

  always_comb begin
    load_val = 8'd0;
    case (next_state)
      SETUP:          load_val = 8'(CS_SETUP - 1);
      SCK_HI, SCK_LO: load_val = 8'(CLK_DIV_HALF - 1);
      HOLD:           load_val = 8'(CS_HOLD - 1);
      GAP:            load_val = 8'(CS_GAP - 1);
      default:        load_val = 8'd0;
    endcase
  end

  // Counter holds at zero so a state may linger past its nominal length.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (next_state != state) begin
      cnt <= load_val;
    end else if (cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  assign phase_done = (cnt == 8'd0);
  assign sck_rise   = phase_done && (state == SETUP || state == SCK_LO);
  assign sck_fall   = phase_done && (state == SCK_HI);

endmodule

// File: rtl/spi_master.sv
// SPI master, CPOL=0 / CPHA=1, 1..8 byte transfers, MSB first, with
// programmable chip-select setup, hold and gap timing.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV_HALF = DEF_CLK_DIV_HALF,
  parameter int CS_SETUP     = DEF_CS_SETUP,
  parameter int CS_HOLD      = DEF_CS_HOLD,
  parameter int CS_GAP       = DEF_CS_GAP
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [3:0]  byte_count,
  input  logic [63:0] tx_data,
  output logic [63:0] rx_data,
  output logic        busy,
  output logic        done,
  output logic        SCK,
  output logic        CSEL,
  output logic        MOSI,
  input  logic        MISO
);

  spi_state_t  state;
  spi_state_t  next_state;
  logic        rst_meta;
  logic        rst_n;
  logic        phase_done;
  logic        sck_rise;
  logic        sck_fall;
  logic        accept;
  logic        cap_pending;
  logic        sck_d;
  logic        csel_d;
  logic        busy_d;
  logic        done_d;
  logic [6:0]  nbits;
  logic [6:0]  bit_cnt;
  logic [63:0] tx_aligned;
  logic [63:0] tx_sr;
  logic [63:0] rx_sr;
  logic        miso_meta;
  logic        miso_sync;
  logic        fall_d1;
  logic        fall_d2;

  // Reset asserts asynchronously but releases only after two clock edges.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rst_meta <= 1'b0;
      rst_n    <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_n    <= rst_meta;
    end
  end

  assign nbits       = calc_nbits(byte_count);
  assign tx_aligned  = tx_data << (7'd64 - nbits);
  assign accept      = (state == IDLE) && start;
  assign cap_pending = fall_d1 || fall_d2;

  spi_clk_gen #(
    .CLK_DIV_HALF (CLK_DIV_HALF),
    .CS_SETUP     (CS_SETUP),
    .CS_HOLD      (CS_HOLD),
    .CS_GAP       (CS_GAP)
  ) u_clk_gen (
    .CLK        (CLK),
    .rst_n      (rst_n),
    .state      (state),
    .next_state (next_state),
    .phase_done (phase_done),
    .sck_rise   (sck_rise),
    .sck_fall   (sck_fall)
  );

  // The final fall goes straight to HOLD so CS_HOLD is measured from it;
  // HOLD also waits for the delayed capture of the last MISO bit.
  always_comb begin
    next_state = state;
    sck_d      = 1'b0;
    csel_d     = 1'b1;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    case (state)
      IDLE:    if (start) next_state = SETUP;
      SETUP:   if (phase_done) next_state = SCK_HI;
      SCK_HI:  if (phase_done) next_state = (bit_cnt == 7'd1) ? HOLD : SCK_LO;
      SCK_LO:  if (phase_done) next_state = SCK_HI;
      HOLD:    if (phase_done && !cap_pending) next_state = GAP;
      GAP:     if (phase_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    sck_d  = (next_state == SCK_HI);
    csel_d = !(next_state == SETUP || next_state == SCK_HI ||
               next_state == SCK_LO || next_state == HOLD);
    busy_d = (next_state != IDLE);
    done_d = (state == HOLD) && (next_state == GAP);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      SCK   <= 1'b0;
      CSEL  <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      SCK   <= sck_d;
      CSEL  <= csel_d;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

  // MISO is captured two cycles after the fall strobe, which lines the
  // synchronizer output up with the level present at the fall itself.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      tx_sr     <= 64'd0;
      rx_sr     <= 64'd0;
      rx_data   <= 64'd0;
      bit_cnt   <= 7'd0;
      MOSI      <= 1'b0;
      miso_meta <= 1'b0;
      miso_sync <= 1'b0;
      fall_d1   <= 1'b0;
      fall_d2   <= 1'b0;
    end else begin
      miso_meta <= MISO;
      miso_sync <= miso_meta;
      fall_d1   <= sck_fall;
      fall_d2   <= fall_d1;
      if (accept) begin
        tx_sr   <= tx_aligned;
        MOSI    <= tx_aligned[63];
        bit_cnt <= nbits;
        rx_sr   <= 64'd0;
      end else begin
        if (sck_rise) MOSI <= tx_sr[63];
        if (sck_fall) begin
          tx_sr   <= {tx_sr[62:0], 1'b0};
          bit_cnt <= bit_cnt - 7'd1;
        end
        if (fall_d2) rx_sr <= {rx_sr[62:0], miso_sync};
      end
      if (done_d) rx_data <= rx_sr;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: loopback and slave-model transfers, wire
// timing, ignored mid-transfer requests, back-to-back starts and reset abort.
module tb_spi_master;
  import spi_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  byte_count = 4'd0;
  logic [63:0] tx_data = 64'd0;
  logic [63:0] rx_data;
  logic        busy, done, sck, csel, mosi, miso;
  logic        use_slave = 1'b0;

  int compared = 0;
  int mismatched = 0;

  int cyc = 0;
  int rise_cnt = 0, fall_cnt = 0, done_cnt = 0, done_total = 0, csel_falls = 0;
  int csel_fall_cyc = 0, csel_rise_cyc = 0;
  int first_rise_cyc = 0, second_rise_cyc = 0, last_fall_cyc = 0;
  logic [63:0] mosi_bits = 64'd0;
  logic prev_sck = 1'b0, prev_csel = 1'b1;

  logic [15:0] sl_out = 16'd0, sl_rx = 16'd0;
  logic sl_miso = 1'b0, sl_prev_sck = 1'b0, sl_prev_csel = 1'b1;

  always #5 clk = ~clk;

  assign miso = use_slave ? sl_miso : mosi;

  spi_master dut (
    .CLK        (clk),
    .RST        (rst),
    .start      (start),
    .byte_count (byte_count),
    .tx_data    (tx_data),
    .rx_data    (rx_data),
    .busy       (busy),
    .done       (done),
    .SCK        (sck),
    .CSEL       (csel),
    .MOSI       (mosi),
    .MISO       (miso)
  );

  // Wire monitor; per-transfer counters restart on every CSEL fall.
  always @(negedge clk) begin
    cyc++;
    if (prev_csel && !csel) begin
      csel_fall_cyc = cyc;
      csel_falls++;
      rise_cnt  = 0;
      fall_cnt  = 0;
      done_cnt  = 0;
      mosi_bits = 64'd0;
    end
    if (!prev_csel && csel) csel_rise_cyc = cyc;
    if (!prev_sck && sck) begin
      if (rise_cnt == 0) first_rise_cyc = cyc;
      if (rise_cnt == 1) second_rise_cyc = cyc;
      rise_cnt++;
    end
    if (prev_sck && !sck) begin
      fall_cnt++;
      last_fall_cyc = cyc;
      mosi_bits = {mosi_bits[62:0], mosi};
    end
    if (done) begin
      done_cnt++;
      done_total++;
    end
    prev_csel = csel;
    prev_sck  = sck;
  end

  // 16-bit slave model: drives on SCK rise, samples on SCK fall.
  always @(sck or csel) begin
    if (sl_prev_csel && !csel) begin
      sl_out = 16'h1234;
      sl_rx  = 16'd0;
    end else if (!csel && sck && !sl_prev_sck) begin
      sl_miso = sl_out[15];
      sl_out  = {sl_out[14:0], 1'b0};
    end else if (!csel && !sck && sl_prev_sck) begin
      sl_rx = {sl_rx[14:0], mosi};
    end
    sl_prev_csel = csel;
    sl_prev_sck  = sck;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitIdle(input string tag);
    int w = 0;
    while (busy !== 1'b0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    checkOutput(tag, busy, 64'd0);
  endtask

  task automatic applyStimulus(input logic [3:0] bc, input logic [63:0] tx);
    waitIdle("idle_before_start");
    @(negedge clk);
    byte_count = bc;
    tx_data    = tx;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic waitDone(input string tag, input int target);
    int w = 0;
    while (done_total < target && w < 3000) begin
      @(negedge clk);
      w++;
    end
    checkOutput(tag, 64'(done_total >= target), 64'd1);
    waitIdle({tag, "_idle"});
  endtask

  task automatic waitRises(input string tag, input int n);
    int w = 0;
    while (rise_cnt < n && w < 3000) begin
      @(negedge clk);
      w++;
    end
    checkOutput(tag, 64'(rise_cnt >= n), 64'd1);
  endtask

  task automatic waitCselFalls(input string tag, input int n);
    int w = 0;
    while (csel_falls < n && w < 3000) begin
      @(negedge clk);
      w++;
    end
    checkOutput(tag, 64'(csel_falls >= n), 64'd1);
  endtask

  initial begin : main
    int base;
    int falls_seen;

    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_sck",  sck,     64'd0);
    checkOutput("reset_csel", csel,    64'd1);
    checkOutput("reset_mosi", mosi,    64'd0);
    checkOutput("reset_busy", busy,    64'd0);
    checkOutput("reset_done", done,    64'd0);
    checkOutput("reset_rx",   rx_data, 64'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] two-byte loopback 0xA55A");
    base = done_total;
    applyStimulus(STD_TWO_BY, 64'h1111_2222_3333_A55A);
    waitDone("a55a_done", base + 1);
    checkOutput("a55a_rises",  rise_cnt,  64'd16);
    checkOutput("a55a_falls",  fall_cnt,  64'd16);
    checkOutput("a55a_mosi",   mosi_bits, 64'h0000_0000_0000_A55A);
    checkOutput("a55a_rx",     rx_data,   64'h0000_0000_0000_A55A);
    checkOutput("a55a_dones",  done_cnt,  64'd1);
    checkOutput("a55a_setup",  first_rise_cyc - csel_fall_cyc,  64'd8);
    checkOutput("a55a_period", second_rise_cyc - first_rise_cyc, 64'd16);
    checkOutput("a55a_hold",   csel_rise_cyc - last_fall_cyc,   64'd8);

    $display("[TB] slave model exchange");
    use_slave = 1'b1;
    base = done_total;
    applyStimulus(STD_TWO_BY, 64'hFFFF_FFFF_FFFF_C3E1);
    waitDone("slave_done", base + 1);
    checkOutput("slave_rx",     rx_data,  64'h0000_0000_0000_1234);
    checkOutput("slave_recv",   sl_rx,    64'h0000_0000_0000_C3E1);
    checkOutput("slave_rises",  rise_cnt, 64'd16);
    use_slave = 1'b0;

    $display("[TB] byte_count 0 runs a full 64-bit transfer");
    base = done_total;
    applyStimulus(NO_BY, 64'h0123_4567_89AB_CDEF);
    waitDone("full_done", base + 1);
    checkOutput("full_rises", rise_cnt, 64'd64);
    checkOutput("full_falls", fall_cnt, 64'd64);
    checkOutput("full_rx",    rx_data,  64'h0123_4567_89AB_CDEF);

    $display("[TB] byte_count 12 clamps to 8 bytes");
    base = done_total;
    applyStimulus(4'd12, 64'hFEDC_BA98_7654_3210);
    waitDone("clamp_done", base + 1);
    checkOutput("clamp_rises", rise_cnt, 64'd64);
    checkOutput("clamp_rx",    rx_data,  64'hFEDC_BA98_7654_3210);

    $display("[TB] start and tx_data change while busy are ignored");
    base = done_total;
    applyStimulus(ONE_BY, 64'h0000_0000_0000_003C);
    waitRises("mid_rises3", 3);
    checkOutput("mid_rx_hold", rx_data, 64'hFEDC_BA98_7654_3210);
    checkOutput("mid_busy",    busy,    64'd1);
    byte_count = 4'd8;
    tx_data    = 64'hFFFF_FFFF_FFFF_FFFF;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone("mid_done", base + 1);
    checkOutput("mid_rx",    rx_data,   64'h0000_0000_0000_003C);
    checkOutput("mid_rises", rise_cnt,  64'd8);
    checkOutput("mid_mosi",  mosi_bits, 64'h0000_0000_0000_003C);
    checkOutput("mid_dones", done_cnt,  64'd1);
    repeat (40) @(negedge clk);
    checkOutput("mid_not_queued", done_total, 64'(base + 1));

    $display("[TB] start held high gives back-to-back transfers");
    base = done_total;
    waitIdle("b2b_idle");
    @(negedge clk);
    byte_count = ONE_BY;
    tx_data    = 64'h0000_0000_0000_0081;
    start      = 1'b1;
    waitDone("b2b_first", base + 1);
    falls_seen = csel_falls;
    waitCselFalls("b2b_second_start", falls_seen + 1);
    checkOutput("b2b_gap", csel_fall_cyc - csel_rise_cyc, 64'd9);
    @(negedge clk);
    start = 1'b0;
    waitDone("b2b_second", base + 2);
    checkOutput("b2b_rx", rx_data, 64'h0000_0000_0000_0081);
    repeat (30) @(negedge clk);
    checkOutput("b2b_stopped", done_total, 64'(base + 2));

    $display("[TB] reset during an 8-byte transfer");
    base = done_total;
    applyStimulus(LONG + 4'd1, 64'h0123_4567_89AB_CDEF);
    waitRises("abort_rises5", 5);
    rst = 1'b0;
    #1;
    checkOutput("abort_csel", csel,    64'd1);
    checkOutput("abort_sck",  sck,     64'd0);
    checkOutput("abort_busy", busy,    64'd0);
    checkOutput("abort_done", done,    64'd0);
    checkOutput("abort_mosi", mosi,    64'd0);
    checkOutput("abort_rx",   rx_data, 64'd0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("abort_no_done", done_total, 64'(base));
    applyStimulus(THREE_BY, 64'hFFFF_FFFF_FF5A_C396);
    waitDone("recover_done", base + 1);
    checkOutput("recover_rises", rise_cnt, 64'd24);
    checkOutput("recover_rx",    rx_data,  64'h0000_0000_005A_C396);
    checkOutput("recover_dones", done_cnt, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
